// File: rtl/irq_controller_if.sv
// Host bus and CPU acknowledge bundle for irq_controller.
//   cs/rd/wr/a/idata/odata : register bus (same style as the timer block)
//   inta                   : CPU interrupt acknowledge, level
//   intr                   : interrupt request to the CPU
// The master modport is the CPU/host side; the slave modport is the controller.
interface irq_controller_if;
    logic       cs;
    logic       rd;
    logic       wr;
    logic       a;
    logic [7:0] idata;
    logic [7:0] odata;
    logic       inta;
    logic       intr;

    modport master (
        output cs, rd, wr, a, idata, inta,
        input  odata, intr
    );

    modport slave (
        input  cs, rd, wr, a, idata, inta,
        output odata, intr
    );
endinterface

// File: rtl/irq_controller.sv
// Eight-input, edge-triggered, fixed-priority interrupt controller.
// Request lines are synchronised, rising edges are latched into IRR, and intr is raised
// for the highest-priority unmasked request that outranks everything in service. An inta
// rising edge moves the selected request into ISR and latches a vector {BASE, level}.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   ir[7:0]  : asynchronous request lines, ir[0] highest priority
//   bus      : host bus (cs/rd/wr/a/idata/odata) plus inta/intr handshake
module irq_controller #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IMR_RESET   = 8'hFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       ir,
    irq_controller_if.slave  bus
);

    // Returns index of the lowest set bit, or 8 when nothing is set.
    function automatic logic [3:0] lowest_set(input logic [7:0] v);
        logic [3:0] idx;
        idx = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [7:0] hist_q;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] imr_q, imr_d;
    logic [4:0] base_q, base_d;
    logic [7:0] vector_q, vector_d;
    logic       intr_q, intr_d;
    logic       wr_lvl_q;
    logic       inta_q;

    logic [7:0] ir_edge;
    logic [7:0] req;
    logic [3:0] sel;
    logic [3:0] cur;
    logic       wr_lvl;
    logic       wr_fire;
    logic       ack;
    logic       grant;
    logic [7:0] isr_eoi;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], ir};
    assign ir_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

    assign req     = irr_q & ~imr_q;
    assign sel     = lowest_set(req);
    assign cur     = lowest_set(isr_q);
    assign wr_lvl  = bus.cs & bus.wr;
    assign wr_fire = wr_lvl & ~wr_lvl_q;
    assign ack     = bus.inta & ~inta_q;
    assign grant   = ack && (req != 8'd0) && (sel < cur);

    always_comb begin
        isr_eoi  = isr_q;
        irr_d    = irr_q;
        imr_d    = imr_q;
        base_d   = base_q;
        vector_d = vector_q;

        // EOI applies to the pre-ack ISR; the ack then sets its own bit on top.
        if (wr_fire && !bus.a) begin
            if (bus.idata[7]) begin
                base_d = bus.idata[7:3];
            end else if (bus.idata[7:5] == 3'b001) begin
                if (isr_q != 8'd0) isr_eoi[cur[2:0]] = 1'b0;
            end else if (bus.idata[7:5] == 3'b011) begin
                isr_eoi[bus.idata[2:0]] = 1'b0;
            end
        end
        if (wr_fire && bus.a) begin
            imr_d = bus.idata;
        end

        isr_d = isr_eoi;
        if (grant) begin
            isr_d[sel[2:0]] = 1'b1;
            irr_d[sel[2:0]] = 1'b0;
        end
        // A fresh edge in the ack cycle wins over the clear.
        irr_d = irr_d | ir_edge;

        if (ack) begin
            vector_d = grant ? {base_q, sel[2:0]} : {base_q, 3'b111};
        end

        intr_d = !bus.inta && (req != 8'd0) && (sel < cur);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            hist_q   <= 8'd0;
            irr_q    <= 8'd0;
            isr_q    <= 8'd0;
            imr_q    <= IMR_RESET;
            base_q   <= 5'd0;
            vector_q <= 8'd0;
            intr_q   <= 1'b0;
            wr_lvl_q <= 1'b0;
            inta_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            hist_q   <= sync_q[SYNC_STAGES-1];
            irr_q    <= irr_d;
            isr_q    <= isr_d;
            imr_q    <= imr_d;
            base_q   <= base_d;
            vector_q <= vector_d;
            intr_q   <= intr_d;
            wr_lvl_q <= wr_lvl;
            inta_q   <= bus.inta;
        end
    end

    assign bus.intr = intr_q;

    always_comb begin
        bus.odata = 8'd0;
        if (bus.inta) begin
            bus.odata = vector_q;
        end else if (bus.cs && bus.rd) begin
            bus.odata = bus.a ? imr_q : irr_q;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset state, masking, basic ack, priority and
// nesting, spurious ack, same-cycle edge on ack, asynchronous square-wave sources and
// reset in the middle of a handshake.
module tb_irq_controller;

    logic       clk;
    logic       reset_n;
    logic [7:0] ir_dir;
    logic       ir_g0, ir_g1, ir_g2;
    logic [7:0] ir;
    logic [7:0] v;
    logic       gen_done;
    int         checks;
    int         errors;
    int         cnt0, cnt1, cnt2, bad, total;

    irq_controller_if bus ();

    assign ir = ir_dir | {5'd0, ir_g2, ir_g1, ir_g0};

    irq_controller #(
        .SYNC_STAGES(2),
        .IMR_RESET  (8'hFF)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .ir     (ir),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic addr, input logic [7:0] data);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.a = addr; bus.idata = data;
        tick();
        bus.cs = 1'b0; bus.wr = 1'b0;
        tick();
    endtask

    task automatic rd_reg(input logic addr, output logic [7:0] data);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.a = addr;
        #1;
        data = bus.odata;
        bus.cs = 1'b0; bus.rd = 1'b0;
    endtask

    // Full inta pulse; returns the vector and intr as seen while inta is high.
    task automatic do_ack(output logic [7:0] vec, output logic intr_hi);
        bus.inta = 1'b1;
        tick();
        vec     = bus.odata;
        intr_hi = bus.intr;
        bus.inta = 1'b0;
        tick();
    endtask

    task automatic gen_line(input int idx, input int hp);
        repeat (4) begin
            #(hp);
            if (idx == 0) ir_g0 = 1'b1; else if (idx == 1) ir_g1 = 1'b1; else ir_g2 = 1'b1;
            #(hp);
            if (idx == 0) ir_g0 = 1'b0; else if (idx == 1) ir_g1 = 1'b0; else ir_g2 = 1'b0;
        end
    endtask

    initial begin
        logic ih;
        checks = 0; errors = 0;
        cnt0 = 0; cnt1 = 0; cnt2 = 0; bad = 0; total = 0;
        gen_done = 1'b0;
        ir_dir = 8'd0; ir_g0 = 1'b0; ir_g1 = 1'b0; ir_g2 = 1'b0;
        bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.a = 1'b0;
        bus.idata = 8'd0; bus.inta = 1'b0;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_intr", {7'd0, bus.intr}, 8'd0);
        rd_reg(1'b1, v); chk("rst_imr", v, 8'hFF);
        rd_reg(1'b0, v); chk("rst_irr", v, 8'h00);

        // Masked line still latches into IRR
        ir_dir[3] = 1'b1;
        repeat (4) tick();
        ir_dir[3] = 1'b0;
        tick();
        rd_reg(1'b0, v); chk("masked_irr", v, 8'h08);
        chk("masked_intr", {7'd0, bus.intr}, 8'd0);

        // Setup; unmasking exposes the pending ir[3]
        wr_reg(1'b0, 8'hA0);
        wr_reg(1'b1, 8'h00);
        chk("unmask_intr", {7'd0, bus.intr}, 8'd1);
        do_ack(v, ih); chk("ack3_vec", v, 8'hA3);
        rd_reg(1'b0, v); chk("ack3_irr", v, 8'h00);
        wr_reg(1'b0, 8'h20);

        // Basic ack with k+3 latency
        ir_dir[5] = 1'b1;
        tick(); tick(); tick();
        chk("lat_k2_intr", {7'd0, bus.intr}, 8'd0);
        tick();
        chk("lat_k3_intr", {7'd0, bus.intr}, 8'd1);
        ir_dir[5] = 1'b0;
        do_ack(v, ih);
        chk("ack5_vec", v, 8'hA5);
        chk("ack5_intr", {7'd0, ih}, 8'd0);
        rd_reg(1'b0, v); chk("ack5_irr", v, 8'h00);
        wr_reg(1'b0, 8'h20);
        chk("eoi5_intr", {7'd0, bus.intr}, 8'd0);

        // Priority and nesting
        ir_dir[6] = 1'b1; repeat (4) tick(); ir_dir[6] = 1'b0;
        chk("n6_intr", {7'd0, bus.intr}, 8'd1);
        do_ack(v, ih); chk("n6_vec", v, 8'hA6);
        ir_dir[2] = 1'b1; repeat (4) tick(); ir_dir[2] = 1'b0;
        chk("n2_intr", {7'd0, bus.intr}, 8'd1);
        do_ack(v, ih); chk("n2_vec", v, 8'hA2);
        ir_dir[7] = 1'b1; repeat (4) tick(); ir_dir[7] = 1'b0;
        chk("n7_blocked", {7'd0, bus.intr}, 8'd0);
        wr_reg(1'b0, 8'h20);
        chk("n7_eoi1", {7'd0, bus.intr}, 8'd0);
        wr_reg(1'b0, 8'h20);
        chk("n7_eoi2", {7'd0, bus.intr}, 8'd1);
        do_ack(v, ih); chk("n7_vec", v, 8'hA7);
        wr_reg(1'b0, 8'h20);

        // Spurious ack
        do_ack(v, ih);
        chk("spur_vec", v, 8'hA7);
        rd_reg(1'b0, v); chk("spur_irr", v, 8'h00);
        chk("spur_intr", {7'd0, bus.intr}, 8'd0);

        // Second rise on ir[4] lands exactly on its ack edge
        ir_dir[4] = 1'b1; repeat (4) tick(); ir_dir[4] = 1'b0;
        chk("same_intr", {7'd0, bus.intr}, 8'd1);
        repeat (3) tick();
        ir_dir[4] = 1'b1;
        tick(); tick();
        bus.inta = 1'b1;
        tick();
        chk("same_vec", bus.odata, 8'hA4);
        bus.inta = 1'b0;
        ir_dir[4] = 1'b0;
        tick();
        rd_reg(1'b0, v); chk("same_irr", v, 8'h10);
        chk("same_insvc", {7'd0, bus.intr}, 8'd0);
        wr_reg(1'b0, 8'h64);
        chk("same_seoi", {7'd0, bus.intr}, 8'd1);
        do_ack(v, ih); chk("same_vec2", v, 8'hA4);
        wr_reg(1'b0, 8'h20);
        rd_reg(1'b0, v); chk("same_irr2", v, 8'h00);

        // Asynchronous square-wave sources on ir[0..2]
        fork
            begin
                fork
                    gen_line(0, 403);
                    gen_line(1, 517);
                    gen_line(2, 661);
                join
                gen_done = 1'b1;
            end
        join_none
        for (int c = 0; c < 3000; c++) begin
            if (gen_done && total == 12 && !bus.intr) break;
            if (bus.intr) begin
                do_ack(v, ih);
                total++;
                if (v == 8'hA0) cnt0++;
                else if (v == 8'hA1) cnt1++;
                else if (v == 8'hA2) cnt2++;
                else bad++;
                wr_reg(1'b0, 8'h20);
            end else begin
                tick();
            end
        end
        chk("async_done", {7'd0, gen_done}, 8'd1);
        chk("async_cnt0", 8'(cnt0), 8'd4);
        chk("async_cnt1", 8'(cnt1), 8'd4);
        chk("async_cnt2", 8'(cnt2), 8'd4);
        chk("async_bad", 8'(bad), 8'd0);
        rd_reg(1'b0, v); chk("async_irr", v, 8'h00);

        // Reset in the middle of a handshake
        bus.inta = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.inta = 1'b0;
        tick();
        chk("mrst_intr", {7'd0, bus.intr}, 8'd0);
        do_ack(v, ih); chk("mrst_vec", v, 8'h07);
        rd_reg(1'b1, v); chk("mrst_imr", v, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
